// File: rtl/shift_delay_pkg.sv
// Shared types and helpers for the selectable-delay byte pipeline controller.
package shift_delay_pkg;

   // Controller states: RUN accepts input and config; DRAIN flushes the old tap.
   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Width of a delay field able to hold 0..max_delay (never narrower than 1 bit).
   function automatic int delay_width(input int max_delay);
      return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
   endfunction

   // Requests beyond the deepest stage saturate at the deepest stage.
   function automatic int clamp_delay(input int req, input int max_delay);
      return (req > max_delay) ? max_delay : req;
   endfunction

endpackage

// File: rtl/shift_delay_ctrl_stage.sv
// One pipeline stage: a data register plus its valid flag, both cleared by reset.
module delay_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   // Shift the sample and its valid flag by one stage every cycle.
   // NOTE: clocked state uses non-blocking assignments so every stage samples
   // its predecessor's pre-edge value; blocking here would collapse the chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_data  <= i_data;
         r_valid <= i_valid;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/shift_delay_ctrl.sv
// Selectable-delay byte pipeline controller: stage chain, output tap mux and
// the RUN/DRAIN sequencer that switches taps without losing in-flight samples.
module shift_delay_ctrl
   import shift_delay_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_DELAY = 3,
   parameter int DW        = delay_width(MAX_DELAY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   input  logic [DW-1:0]    cfg_delay,
   output logic             cfg_ready,
   output logic             cfg_ack,
   output logic [DW-1:0]    cur_delay,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [DW-1:0] r_cur_delay;
   logic [DW-1:0] w_cur_nxt;
   logic [DW-1:0] r_pend_delay;
   logic [DW-1:0] w_pend_nxt;
   logic [DW-1:0] r_drain_cnt;
   logic [DW-1:0] w_cnt_nxt;
   logic          r_cfg_ack;
   logic          w_ack_nxt;
   logic [DW-1:0] w_cfg_clamped;
   logic          w_accept;

   // Chain element 0 is the live input; element k (k>=1) is the output of stage k-1,
   // so the tap for delay d is simply element d.
   logic [WIDTH-1:0] w_chain_data  [0:MAX_DELAY];
   logic             w_chain_valid [0:MAX_DELAY];

   assign w_accept         = in_valid && in_ready;
   assign w_chain_data[0]  = in_data;
   assign w_chain_valid[0] = w_accept;
   assign w_cfg_clamped    = DW'(clamp_delay(int'(cfg_delay), MAX_DELAY));

   genvar k;
   generate
      for (k = 0; k < MAX_DELAY; k++) begin : g_stage
         delay_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_data  (w_chain_data[k]),
            .i_valid (w_chain_valid[k]),
            .o_data  (w_chain_data[k+1]),
            .o_valid (w_chain_valid[k+1])
         );
      end
   endgenerate

   // Output tap; valid is forced low while reset is asserted because the d=0
   // path is combinational from the input.
   assign out_data  = w_chain_data[r_cur_delay];
   assign out_valid = !rst && w_chain_valid[r_cur_delay];
   assign cur_delay = r_cur_delay;
   assign cfg_ack   = r_cfg_ack;

   // Register the sequencer state, the active/pending taps, drain counter and ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= RUN;
         r_cur_delay  <= '0;
         r_pend_delay <= '0;
         r_drain_cnt  <= '0;
         r_cfg_ack    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cur_delay  <= w_cur_nxt;
         r_pend_delay <= w_pend_nxt;
         r_drain_cnt  <= w_cnt_nxt;
         r_cfg_ack    <= w_ack_nxt;
      end
   end

   // Next-state logic: immediate switch when nothing can be in flight at a
   // different tap, otherwise block input for old-delay cycles before switching.
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur_delay;
      w_pend_nxt  = r_pend_delay;
      w_cnt_nxt   = r_drain_cnt;
      w_ack_nxt   = 1'b0;
      in_ready    = 1'b1;
      cfg_ready   = 1'b1;
      case (r_state)
         RUN: begin
            if (cfg_valid) begin
               w_pend_nxt = w_cfg_clamped;
               if ((w_cfg_clamped == r_cur_delay) || (r_cur_delay == '0)) begin
                  w_cur_nxt = w_cfg_clamped;
                  w_ack_nxt = 1'b1;
               end else begin
                  w_state_nxt = DRAIN;
                  w_cnt_nxt   = r_cur_delay;
               end
            end
         end
         DRAIN: begin
            in_ready  = 1'b0;
            cfg_ready = 1'b0;
            w_cnt_nxt = r_drain_cnt - DW'(1);
            if (r_drain_cnt == DW'(1)) begin
               w_cur_nxt   = r_pend_delay;
               w_state_nxt = RUN;
               w_ack_nxt   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

endmodule
